// File: rtl/mem_port_arbiter.sv
// Arbiter and sequencer for the single ram port shared by instruction fetch and the
// load/store path: one transaction at a time, data priority with a fetch starvation guard.
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int unsigned MAX_DATA_STREAK = 4,
  parameter int unsigned TIMEOUT         = 255,
  parameter logic [2:0]  MEM_WORD        = 3'd2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_adr,
  output logic        if_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_adr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_siz,
  output logic        d_ack,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy,
  output logic        mem_start,
  output logic [31:0] mem_adr,
  output logic        mem_load,
  output logic [31:0] mem_in,
  output logic [2:0]  mem_siz,
  input  logic [31:0] mem_out,
  input  logic        mem_busy,
  input  logic        mem_done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [2:0] STREAK_MAX = 3'(MAX_DATA_STREAK);
  localparam logic [7:0] TIMEOUT_C  = 8'(TIMEOUT);

  logic [1:0]  state_q, state_d;
  logic        owner_q, owner_d;
  logic [2:0]  streak_q, streak_d;
  logic [7:0]  tcnt_q, tcnt_d;
  logic        mem_start_q, mem_start_d;
  logic [31:0] mem_adr_q, mem_adr_d;
  logic        mem_load_q, mem_load_d;
  logic [31:0] mem_in_q, mem_in_d;
  logic [2:0]  mem_siz_q, mem_siz_d;
  logic        if_ack_q, if_ack_d;
  logic        d_ack_q, d_ack_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;

  logic        grant_d_s;
  logic [2:0]  streak_inc_s;
  logic [7:0]  tcnt_inc_s;

  // Data wins a tie unless it has already taken MAX_DATA_STREAK grants past a waiting fetch.
  assign grant_d_s    = d_req && (!if_req || (streak_q != STREAK_MAX));
  assign streak_inc_s = (streak_q == STREAK_MAX) ? streak_q : streak_q + 3'd1;
  assign tcnt_inc_s   = tcnt_q + 8'd1;

  // Next-state and output-register logic for the IDLE/ISSUE/WAIT/RESP sequencer.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    streak_d    = streak_q;
    tcnt_d      = tcnt_q;
    mem_start_d = mem_start_q;
    mem_adr_d   = mem_adr_q;
    mem_load_d  = mem_load_q;
    mem_in_d    = mem_in_q;
    mem_siz_d   = mem_siz_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    rdata_d     = rdata_q;
    err_d       = err_q;
    busy_d      = busy_q;
    case (state_q)
      S_IDLE: begin
        if (grant_d_s) begin
          owner_d     = 1'b1;
          mem_adr_d   = d_adr;
          mem_load_d  = d_we;
          mem_in_d    = d_wdata;
          mem_siz_d   = d_siz;
          streak_d    = if_req ? streak_inc_s : 3'd0;
          tcnt_d      = 8'd0;
          mem_start_d = 1'b1;
          busy_d      = 1'b1;
          state_d     = S_ISSUE;
        end else if (if_req) begin
          owner_d     = 1'b0;
          mem_adr_d   = if_adr;
          mem_load_d  = 1'b0;
          mem_in_d    = 32'd0;
          mem_siz_d   = MEM_WORD;
          streak_d    = 3'd0;
          tcnt_d      = 8'd0;
          mem_start_d = 1'b1;
          busy_d      = 1'b1;
          state_d     = S_ISSUE;
        end else begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        tcnt_d = tcnt_inc_s;
        // Completion is checked first so a done on the last allowed cycle is not an error.
        if (mem_done && !mem_busy) begin
          rdata_d     = mem_out;
          err_d       = 1'b0;
          mem_start_d = 1'b0;
          if_ack_d    = !owner_q;
          d_ack_d     = owner_q;
          state_d     = S_RESP;
        end else if (tcnt_inc_s == TIMEOUT_C) begin
          rdata_d     = 32'd0;
          err_d       = 1'b1;
          mem_start_d = 1'b0;
          if_ack_d    = !owner_q;
          d_ack_d     = owner_q;
          state_d     = S_RESP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RESP: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        mem_start_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any in-flight transaction without an ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      streak_q    <= 3'd0;
      tcnt_q      <= 8'd0;
      mem_start_q <= 1'b0;
      mem_adr_q   <= 32'd0;
      mem_load_q  <= 1'b0;
      mem_in_q    <= 32'd0;
      mem_siz_q   <= MEM_WORD;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      rdata_q     <= 32'd0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      streak_q    <= streak_d;
      tcnt_q      <= tcnt_d;
      mem_start_q <= mem_start_d;
      mem_adr_q   <= mem_adr_d;
      mem_load_q  <= mem_load_d;
      mem_in_q    <= mem_in_d;
      mem_siz_q   <= mem_siz_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign rdata     = rdata_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign mem_start = mem_start_q;
  assign mem_adr   = mem_adr_q;
  assign mem_load  = mem_load_q;
  assign mem_in    = mem_in_q;
  assign mem_siz   = mem_siz_q;

endmodule
